// File: rtl/pc_sequencer_if.sv
// Bundles the control, jump-table programming and status signals of the PC sequencer.
// The master modport drives the controls; the slave modport (the sequencer) drives the status outputs.
interface pc_sequencer_if #(
   parameter int D       = 12,
   parameter int ENTRIES = 16,
   parameter int OW      = 8
);
   logic                       start;
   logic                       stall;
   logic                       jump;
   logic                       call;
   logic                       ret;
   logic                       halt;
   logic                       lut_we;
   logic [$clog2(ENTRIES)-1:0] lut_idx;
   logic [D-1:0]               lut_tag;
   logic [OW-1:0]              lut_off;
   logic [D-1:0]               pc;
   logic                       running;
   logic                       done;
   logic                       miss;
   logic                       ras_err;

   modport master (
      output start, stall, jump, call, ret, halt,
      output lut_we, lut_idx, lut_tag, lut_off,
      input  pc, running, done, miss, ras_err
   );

   modport slave (
      input  start, stall, jump, call, ret, halt,
      input  lut_we, lut_idx, lut_tag, lut_off,
      output pc, running, done, miss, ras_err
   );
endinterface

// File: rtl/pc_sequencer.sv
// Registered program-counter sequencer: sequential stepping, table-driven jumps/calls,
// return-address stack, stall and start/halt control with miss and stack-error flags.
module pc_sequencer #(
   parameter int D         = 12,
   parameter int ENTRIES   = 16,
   parameter int OW        = 8,
   parameter int RAS_DEPTH = 4
) (
   input logic           clk,
   input logic           reset_n,
   pc_sequencer_if.slave bus
);
   localparam int AW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
   localparam int SW = $clog2(RAS_DEPTH + 1);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] RUN    = 2'd1;
   localparam logic [1:0] HALTED = 2'd2;

   logic [1:0]         state, state_next;
   logic [D-1:0]       pc, pc_next, pc_inc, off_ext;
   logic [SW-1:0]      sp, sp_next;
   logic               ras_err, ras_err_next;
   logic               miss, miss_next;
   logic               running, done;
   logic               push;
   logic               hit;
   logic [OW-1:0]      hit_off;
   logic [ENTRIES-1:0] valid;
   logic [D-1:0]       tag_mem [ENTRIES];
   logic [OW-1:0]      off_mem [ENTRIES];
   logic [D-1:0]       ras     [2**AW];

   // Scanning downwards lets the lowest matching index overwrite any higher one.
   always_comb begin
      hit     = 1'b0;
      hit_off = '0;
      for (int i = ENTRIES - 1; i >= 0; i--) begin
         if (valid[i] && (tag_mem[i] == pc)) begin
            hit     = 1'b1;
            hit_off = off_mem[i];
         end
      end
   end

   always_comb begin
      state_next   = state;
      pc_next      = pc;
      sp_next      = sp;
      ras_err_next = ras_err;
      miss_next    = 1'b0;
      push         = 1'b0;
      pc_inc       = pc + D'(1);
      off_ext      = D'($signed(hit_off));
      if (!bus.stall) begin
         if (bus.start) begin
            state_next   = RUN;
            pc_next      = '0;
            sp_next      = '0;
            ras_err_next = 1'b0;
         end else if (state == RUN) begin
            if (bus.halt) begin
               state_next = HALTED;
            end else if (bus.ret) begin
               if (sp != '0) begin
                  pc_next = ras[AW'(sp - SW'(1))];
                  sp_next = sp - SW'(1);
               end else begin
                  pc_next      = pc_inc;
                  ras_err_next = 1'b1;
               end
            end else if (bus.jump || bus.call) begin
               if (hit) begin
                  pc_next = pc + off_ext;
               end else begin
                  pc_next   = pc_inc;
                  miss_next = 1'b1;
               end
               if (bus.call) begin
                  if (sp != SW'(RAS_DEPTH)) begin
                     push    = 1'b1;
                     sp_next = sp + SW'(1);
                  end else begin
                     ras_err_next = 1'b1;
                  end
               end
            end else begin
               pc_next = pc_inc;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= IDLE;
         pc      <= '0;
         sp      <= '0;
         ras_err <= 1'b0;
         miss    <= 1'b0;
         running <= 1'b0;
         done    <= 1'b0;
      end else begin
         state   <= state_next;
         pc      <= pc_next;
         sp      <= sp_next;
         ras_err <= ras_err_next;
         miss    <= miss_next;
         running <= (state_next == RUN);
         done    <= (state_next == HALTED);
      end
   end

   // Stack storage needs no reset: entries above sp are never read.
   always_ff @(posedge clk) begin
      if (push) begin
         ras[AW'(sp)] <= pc_inc;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         valid <= '0;
         for (int i = 0; i < ENTRIES; i++) begin
            tag_mem[i] <= '0;
            off_mem[i] <= '0;
         end
      end else if (bus.lut_we) begin
         valid[bus.lut_idx]   <= 1'b1;
         tag_mem[bus.lut_idx] <= bus.lut_tag;
         off_mem[bus.lut_idx] <= bus.lut_off;
      end
   end

   assign bus.pc      = pc;
   assign bus.running = running;
   assign bus.done    = done;
   assign bus.miss    = miss;
   assign bus.ras_err = ras_err;
endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios followed by randomized traffic,
// all compared against an integer/queue reference model of the sequencing rules.
module tb_pc_sequencer;
   localparam int D         = 12;
   localparam int ENTRIES   = 16;
   localparam int OW        = 8;
   localparam int RAS_DEPTH = 4;
   localparam int LW        = $clog2(ENTRIES);
   localparam int PC_MASK   = (1 << D) - 1;

   logic clk     = 1'b0;
   logic reset_n = 1'b0;

   pc_sequencer_if #(.D(D), .ENTRIES(ENTRIES), .OW(OW)) bus ();

   pc_sequencer #(.D(D), .ENTRIES(ENTRIES), .OW(OW), .RAS_DEPTH(RAS_DEPTH)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   int n_vectors     = 0;
   int n_miscompares = 0;

   int m_pc;
   bit m_run, m_done, m_miss, m_err;
   int m_stack[$];
   bit m_valid [ENTRIES];
   int m_tag   [ENTRIES];
   int m_off   [ENTRIES];

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_vectors++;
      if (actual !== expected) begin
         n_miscompares++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic check_all();
      checkOutput("pc",      32'(bus.pc),      32'(m_pc));
      checkOutput("running", 32'(bus.running), 32'(m_run));
      checkOutput("done",    32'(bus.done),    32'(m_done));
      checkOutput("miss",    32'(bus.miss),    32'(m_miss));
      checkOutput("ras_err", 32'(bus.ras_err), 32'(m_err));
   endtask

   task automatic model_reset();
      m_pc   = 0;
      m_run  = 0;
      m_done = 0;
      m_miss = 0;
      m_err  = 0;
      m_stack.delete();
      for (int i = 0; i < ENTRIES; i++) begin
         m_valid[i] = 0;
         m_tag[i]   = 0;
         m_off[i]   = 0;
      end
   endtask

   // Next-state rules applied to the model from the inputs currently on the bus.
   task automatic model_step();
      bit found;
      int offset;
      found  = 0;
      offset = 0;
      m_miss = 0;
      if (!bus.stall) begin
         if (bus.start) begin
            m_run  = 1;
            m_done = 0;
            m_pc   = 0;
            m_err  = 0;
            m_stack.delete();
         end else if (m_run) begin
            if (bus.halt) begin
               m_run  = 0;
               m_done = 1;
            end else if (bus.ret) begin
               if (m_stack.size() > 0) begin
                  m_pc = m_stack.pop_back();
               end else begin
                  m_pc  = (m_pc + 1) & PC_MASK;
                  m_err = 1;
               end
            end else if (bus.jump || bus.call) begin
               for (int i = 0; i < ENTRIES; i++) begin
                  if (!found && m_valid[i] && m_tag[i] == m_pc) begin
                     found  = 1;
                     offset = m_off[i];
                  end
               end
               if (bus.call) begin
                  if (m_stack.size() < RAS_DEPTH) m_stack.push_back((m_pc + 1) & PC_MASK);
                  else m_err = 1;
               end
               if (found) begin
                  m_pc = (m_pc + offset) & PC_MASK;
               end else begin
                  m_pc   = (m_pc + 1) & PC_MASK;
                  m_miss = 1;
               end
            end else begin
               m_pc = (m_pc + 1) & PC_MASK;
            end
         end
      end
      if (bus.lut_we) begin
         m_valid[bus.lut_idx] = 1;
         m_tag[bus.lut_idx]   = int'(bus.lut_tag);
         m_off[bus.lut_idx]   = int'($signed(bus.lut_off));
      end
   endtask

   // One clock of stimulus: drive, advance the model, clock, then compare after the edge.
   task automatic applyStimulus(input bit st, input bit stl, input bit jp, input bit cl,
                                input bit rt, input bit hl, input bit we, input int idx,
                                input int tag, input int off);
      bus.start   = st;
      bus.stall   = stl;
      bus.jump    = jp;
      bus.call    = cl;
      bus.ret     = rt;
      bus.halt    = hl;
      bus.lut_we  = we;
      bus.lut_idx = LW'(idx);
      bus.lut_tag = D'(tag);
      bus.lut_off = OW'(off);
      model_step();
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic write_entry(input int idx, input int tag, input int off);
      applyStimulus(0, 0, 0, 0, 0, 0, 1, idx, tag, off);
   endtask

   // Asynchronous reset pulse placed between clock edges.
   task automatic do_reset();
      reset_n = 1'b0;
      #2;
      model_reset();
      check_all();
      #2;
      reset_n = 1'b1;
   endtask

   initial begin
      bus.start   = 0;
      bus.stall   = 0;
      bus.jump    = 0;
      bus.call    = 0;
      bus.ret     = 0;
      bus.halt    = 0;
      bus.lut_we  = 0;
      bus.lut_idx = '0;
      bus.lut_tag = '0;
      bus.lut_off = '0;
      model_reset();
      #3;
      check_all();
      #4;
      reset_n = 1'b1;
      @(posedge clk);
      #1;

      $display("[TB] sequential stepping");
      applyStimulus(1, 0, 0, 0, 0, 0, 1, 0, 4, 8'hFB);
      checkOutput("start_pc", 32'(bus.pc), 32'h0);
      idle(5);
      checkOutput("seq_pc5", 32'(bus.pc), 32'h5);

      $display("[TB] negative offset and wrap");
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      idle(4);
      applyStimulus(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("jump_neg", 32'(bus.pc), 32'hFFF);
      idle(1);
      checkOutput("wrap", 32'(bus.pc), 32'h000);

      $display("[TB] duplicate tags and lookup miss");
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      write_entry(3, 2, 20);
      write_entry(1, 2, 1);
      applyStimulus(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("dup_low", 32'(bus.pc), 32'h3);
      idle(2);
      applyStimulus(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("miss_pc", 32'(bus.pc), 32'h6);
      checkOutput("miss_hi", 32'(bus.miss), 32'h1);
      idle(1);
      checkOutput("miss_lo", 32'(bus.miss), 32'h0);

      $display("[TB] nested calls and returns");
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      for (int k = 0; k < 5; k++) write_entry(8 + k, 16 * (k + 1), 16);
      idle(11);
      for (int k = 0; k < 5; k++) applyStimulus(0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
      checkOutput("call5_pc", 32'(bus.pc), 32'h60);
      checkOutput("call5_err", 32'(bus.ras_err), 32'h1);
      for (int k = 0; k < 5; k++) applyStimulus(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
      checkOutput("ret_empty", 32'(bus.pc), 32'h12);

      $display("[TB] stall, halt and restart");
      for (int k = 0; k < 3; k++) applyStimulus(0, 1, 1, 0, 0, 1, 0, 0, 0, 0);
      checkOutput("stall_pc", 32'(bus.pc), 32'h12);
      applyStimulus(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
      checkOutput("halt_done", 32'(bus.done), 32'h1);
      idle(2);
      checkOutput("halt_pc", 32'(bus.pc), 32'h12);
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("restart_err", 32'(bus.ras_err), 32'h0);

      $display("[TB] reset mid-run clears the table");
      idle(3);
      do_reset();
      checkOutput("rst_pc", 32'(bus.pc), 32'h0);
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      idle(4);
      applyStimulus(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("rst_miss", 32'(bus.miss), 32'h1);

      $display("[TB] randomized traffic");
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 499) == 0) begin
            do_reset();
         end else begin
            applyStimulus($urandom_range(0, 39) == 0, $urandom_range(0, 5) == 0,
                          $urandom_range(0, 3) == 0,  $urandom_range(0, 5) == 0,
                          $urandom_range(0, 5) == 0,  $urandom_range(0, 39) == 0,
                          $urandom_range(0, 3) == 0,  int'($urandom_range(0, ENTRIES - 1)),
                          (m_pc + int'($urandom_range(0, 3))) & PC_MASK,
                          int'($urandom_range(0, 255)));
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
      $finish;
   end
endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Registered program-counter sequencer for the core fetch stage: the parametrised successor of the combinational next-PC lookup. It holds the PC in a register and steps it sequentially. Jumps and calls take their targets from a runtime-programmable tag/offset table instead of files loaded at elaboration. It adds a return-address stack, stall, start/halt control and error flags.

## Interface
- D, 12: PC width; all PC arithmetic is modulo 2^D.
- ENTRIES, 16: jump-table entries; power of two, ≥2.
- OW, 8: signed offset width, two's complement, OW ≤ D.
- RAS_DEPTH, 4: return-address stack depth, ≥1.
- clk  in  1  sole clock; all state updates on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  begin (or restart) execution at PC 0.
- stall  in  1  freeze PC, state, stack and flags this cycle.
- jump  in  1  taken-branch request for the current PC.
- call  in  1  jump plus push of return address.
- ret  in  1  pop return address into PC.
- halt  in  1  stop execution.
- lut_we  in  1  table write strobe.
- lut_idx  in  $clog2(ENTRIES)  entry written.
- lut_tag  in  D  jump-instruction address stored in the entry.
- lut_off  in  OW  signed offset stored in the entry.
- pc  out  D  current PC, registered.
- running  out  1  high in RUN.
- done  out  1  high in HALTED.
- miss  out  1  one-cycle pulse: jump/call found no matching entry.
- ras_err  out  1  sticky: push on full or pop on empty.

## Operation
- States: IDLE, RUN, HALTED. Reset → IDLE; pc=0, running=0, done=0, miss=0, ras_err=0, all entry valid bits 0, stack empty.
- IDLE: pc holds at 0. start → RUN, pc=0.
- RUN, stall=0: exactly one action per cycle, in priority order:
  - halt → HALTED, pc holds.
  - ret → stack non-empty: pc = popped value. Empty: pc = pc+1, ras_err set.
  - call → perform the jump lookup. If stack not full, push pc+1. If full: no push, stack unchanged, ras_err set; jump still taken.
  - jump → look up the lowest-index valid entry with tag == pc. Hit: pc = pc + sign_ext(off). Miss: pc = pc+1, miss=1 for one cycle.
  - none → pc = pc+1; 2^D−1 wraps to 0.
- RUN, stall=1: pc, state, stack, flags all hold; miss=0. Control inputs are ignored, including halt and start.
- HALTED: pc holds, done=1. start → RUN: pc=0, stack emptied, ras_err cleared, done cleared.
- start while in RUN: restart as above, taking priority over all other controls unless stall=1.
- Table writes: accepted in every state, regardless of stall. A write sets valid[lut_idx] and stores tag/offset. A lookup in the same cycle sees the pre-write contents.
- Duplicate tags are legal; the lowest index wins.
- Pushed return addresses wrap modulo 2^D.

## Timing
- pc reflects the decision one cycle after the controlling inputs are sampled; lookup is single-cycle, zero bubbles.
- miss is asserted in the cycle after the failing lookup, for exactly one cycle.
- ras_err rises the cycle after the offending op and stays high until reset or start.
- running/done are registered and change in the same cycle as the state transition.
- reset_n low mid-operation immediately forces all reset values, including the table; there is no deferred completion.

## Test plan
- Reset, start, 5 idle cycles → pc = 0,1,2,3,4,5; running=1; miss=0.
- Write entry 0 {tag 4, off 8'hFB}, run to pc=4, jump=1 → next pc=12'hFFF. Continue sequentially → pc wraps to 12'h000.
- Entry 3 {tag 2, off +20}, entry 1 {tag 2, off +1}, jump at pc=2 → pc=3 (lowest index wins). Jump at pc=5 with no entry → pc=6, miss high for one cycle.
- RAS_DEPTH=4: five nested calls. The fifth is still taken, ras_err=1. Five rets → first four return the stacked pc+1 values in LIFO order, fifth yields pc+1.
- stall=1 held 3 cycles alongside jump and halt → pc and state unchanged, no miss. Then halt with stall=0 → done=1 and pc frozen. Then start → pc=0, done=0, ras_err=0.
- Assert reset_n low mid-RUN with entries programmed → pc=0, IDLE. A subsequent jump at a previous tag address misses because the table is cleared.
